uart_rx_framed: RTL and testbench

//  Receive end of the UART link: deserialises the asynchronous line driven by the

---
 rtl/uart_rx_framed_pkg.sv | 24 ++
 rtl/uart_rx_framed_bit_sampler.sv | 43 ++++
 rtl/uart_rx_framed.sv | 153 +++++++++++++++
 tb/tb_uart_rx_framed.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_framed_pkg.sv
// Shared constants, FSM state encoding and helper for the UART receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_rx_framed_pkg;

  localparam int   UART_CLKS_PER_BIT = 1085;  // 125 MHz / 115200 baud
  localparam int   UART_DATA_WIDTH   = 8;
  localparam logic START_BIT         = 1'b0;
  localparam logic STOP_BIT          = 1'b1;
  localparam int   CLK_PERIOD_NS     = 8;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // 2-of-3 vote used to filter single-cycle noise on the sampled line.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_framed_bit_sampler.sv
// Line front end: 2-flop synchroniser, falling-edge detect, 3-sample majority vote.
// Latency: 2 cycles from i_rx_serial to the synchronised line; outputs are combinational from it.
// Backpressure: none, free-running every cycle.
//
// Ports:
//   sysclk, rst_n  clock, async active-low reset (all flops reset to idle-high)
//   i_rx_serial    raw asynchronous serial line
//   o_fall_edge    synchronised line was 1 last cycle and is 0 this cycle
//   o_maj_bit      majority of the synchronised line over this and the two previous cycles
module uart_rx_framed_bit_sampler
  import uart_rx_framed_pkg::*;
(
  input  logic sysclk,
  input  logic rst_n,
  input  logic i_rx_serial,
  output logic o_fall_edge,
  output logic o_maj_bit
);

  logic r_sync1;
  logic r_sync2;
  logic r_hist0;  // synchronised line one cycle ago
  logic r_hist1;  // synchronised line two cycles ago

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist0 <= 1'b1;
      r_hist1 <= 1'b1;
    end else begin
      r_sync1 <= i_rx_serial;
      r_sync2 <= r_sync1;
      r_hist0 <= r_sync2;
      r_hist1 <= r_hist0;
    end
  end

  assign o_fall_edge = r_hist0 & ~r_sync2;
  // When the bit counter sits at MID+1 this votes over counts MID-1, MID, MID+1.
  assign o_maj_bit   = maj3(r_hist1, r_hist0, r_sync2);

endmodule

// File: rtl/uart_rx_framed.sv
// UART receiver: deserialises 1 start + DATA_WIDTH data (LSB first) + 1 stop bit into bytes.
// Latency: byte registered on the edge after the stop-bit sample (counter at MID+1 of the stop bit).
// Backpressure: o_valid held until i_ready; a byte completing while one is held and not
//               accepted is dropped and flagged on sticky o_overrun.
//
// Ports:
//   sysclk, rst_n  clock, async active-low reset
//   i_rx_serial    raw serial line, idle high
//   i_ready        consumer accepts o_data when o_valid & i_ready
//   i_clr_err      clears o_overrun (a new overrun in the same cycle wins)
//   o_data         received byte, stable while o_valid
//   o_valid        byte available
//   o_busy         receiver is inside a frame (FSM not idle)
//   o_frame_err    one-cycle pulse when the stop bit is sampled low
//   o_overrun      sticky: a completed byte was dropped
module uart_rx_framed
  import uart_rx_framed_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_WIDTH   = UART_DATA_WIDTH
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic                  i_rx_serial,
  input  logic                  i_ready,
  input  logic                  i_clr_err,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_frame_err,
  output logic                  o_overrun
);

  localparam int MID   = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(MID + 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_WIDTH - 1);

  rx_state_t             r_state;
  rx_state_t             w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_frame_err;
  logic                  r_overrun;

  logic w_fall_edge;
  logic w_maj_bit;
  logic w_at_sample;
  logic w_shift_en;
  logic w_byte_done;
  logic w_stop_bad;

  uart_rx_framed_bit_sampler u_sampler (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .i_rx_serial (i_rx_serial),
    .o_fall_edge (w_fall_edge),
    .o_maj_bit   (w_maj_bit)
  );

  assign w_at_sample = (r_cnt == CNT_SAMPLE);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) r_state <= RX_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Every state change inside a frame happens at a sample point; the counter keeps
  // running, so the next MID+1 falls in the following bit.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_byte_done = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (w_fall_edge) w_state_nxt = RX_START;
      end
      RX_START: begin
        if (w_at_sample) w_state_nxt = (w_maj_bit == START_BIT) ? RX_DATA : RX_IDLE;
      end
      RX_DATA: begin
        if (w_at_sample) begin
          w_shift_en = 1'b1;
          if (r_idx == IDX_LAST) w_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_at_sample) begin
          w_state_nxt = RX_IDLE;
          if (w_maj_bit == STOP_BIT) w_byte_done = 1'b1;
          else                       w_stop_bad  = 1'b1;
        end
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  // The edge-detect cycle is count 0 of the start bit, so the first in-frame cycle is count 1.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n)                 r_cnt <= '0;
    else if (r_state == RX_IDLE) r_cnt <= w_fall_edge ? CNT_W'(1) : '0;
    else if (r_cnt == CNT_LAST)  r_cnt <= '0;
    else                         r_cnt <= r_cnt + CNT_W'(1);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      if (r_state != RX_DATA) r_idx <= '0;
      else if (w_shift_en)    r_idx <= r_idx + IDX_W'(1);
      // LSB arrives first, so shift right and enter at the top.
      if (w_shift_en) r_shift <= {w_maj_bit, r_shift[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      if (w_byte_done) begin
        // Held byte not taken this cycle: keep it, drop the new one.
        if (!r_valid || i_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
      if (w_byte_done && r_valid && !i_ready) r_overrun <= 1'b1;
      else if (i_clr_err)                     r_overrun <= 1'b0;
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_busy      = (r_state != RX_IDLE);
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed at CLKS_PER_BIT=8: frame-level timeline model plus literal checks.
// Latency: n/a.
// Backpressure: i_ready driven from the directed sequence.
module tb_uart_rx_framed
  import uart_rx_framed_pkg::*;
;
  localparam int CPB = 8;
  localparam int DW  = 8;
  localparam int MID = CPB / 2;

  logic          sysclk      = 1'b0;
  logic          rst_n       = 1'b0;
  logic          i_rx_serial = 1'b1;
  logic          i_ready     = 1'b0;
  logic          i_clr_err   = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_busy;
  logic          o_frame_err;
  logic          o_overrun;

  int n_pass = 0;
  int n_chk  = 0;
  bit chk_en = 1'b0;

  uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW)) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .i_rx_serial (i_rx_serial),
    .i_ready     (i_ready),
    .i_clr_err   (i_clr_err),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_busy      (o_busy),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun)
  );

  always #(CLK_PERIOD_NS / 2) sysclk = ~sysclk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Works on a timeline: the line is seen two cycles late; a frame starts at the cycle the
  // seen line goes 1->0 while idle, and bit n is voted at frame offset n*CPB+MID+1 over
  // that cycle and the two before it.
  logic          rd1 = 1'b1, rd2 = 1'b1;   // raw line one and two edges back
  logic          sp1 = 1'b1, sp2 = 1'b1;   // seen line one and two cycles back
  logic          ms, mb, m_stop, m_good;
  bit            in_frame = 1'b0;
  int            k = 0, nb = 0;
  logic [DW-1:0] m_byte = '0;
  logic [DW-1:0] m_last = '0;
  int            m_deliv = 0;
  logic          e_valid = 1'b0, e_ferr = 1'b0, e_ovr = 1'b0, e_busy = 1'b0;
  logic [DW-1:0] e_data = '0;

  always @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      rd1 = 1'b1; rd2 = 1'b1; sp1 = 1'b1; sp2 = 1'b1;
      in_frame = 1'b0; k = 0; nb = 0;
      e_valid = 1'b0; e_ferr = 1'b0; e_ovr = 1'b0; e_busy = 1'b0; e_data = '0;
    end else begin
      ms = rd2; rd2 = rd1; rd1 = i_rx_serial;
      m_stop = 1'b0; m_good = 1'b0;
      if (!in_frame) begin
        if (sp1 && !ms) begin in_frame = 1'b1; k = 0; nb = 0; end
      end else begin
        k++;
        if (k == nb * CPB + MID + 1) begin
          mb = ((int'(sp2) + int'(sp1) + int'(ms)) >= 2);
          if (nb == 0) begin
            if (mb) in_frame = 1'b0;
          end else if (nb <= DW) begin
            m_byte[nb-1] = mb;
          end else begin
            m_stop = 1'b1; m_good = mb; in_frame = 1'b0;
          end
          nb++;
        end
      end
      sp2 = sp1; sp1 = ms;
      e_ferr = m_stop && !m_good;
      if (m_stop && m_good && e_valid && !i_ready) e_ovr = 1'b1;
      else if (i_clr_err)                          e_ovr = 1'b0;
      if (m_stop && m_good) begin
        m_deliv++; m_last = m_byte;
        if (!e_valid || i_ready) begin e_data = m_byte; e_valid = 1'b1; end
      end else if (e_valid && i_ready) begin
        e_valid = 1'b0;
      end
      e_busy = in_frame;
    end
  end

  always @(negedge sysclk) begin
    if (chk_en) begin
      chk("valid", int'(o_valid), int'(e_valid));
      chk("busy", int'(o_busy), int'(e_busy));
      chk("frame_err", int'(o_frame_err), int'(e_ferr));
      chk("overrun", int'(o_overrun), int'(e_ovr));
      if (e_valid) chk("data", int'(o_data), int'(e_data));
    end
  end

  // ---------------- observation counters ----------------
  int            ncyc = 0, vcyc = 0, fcyc = 0, bcyc = 0, vrise = 0, stop_cyc = 0;
  logic [DW-1:0] cap_data = '0;
  logic          pv = 1'b0;

  always @(posedge sysclk) ncyc++;
  always @(negedge sysclk) begin
    if (o_valid) begin vcyc++; cap_data = o_data; end
    if (o_valid && !pv) vrise = ncyc;
    if (o_frame_err) fcyc++;
    if (o_busy) bcyc++;
    pv = o_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // Drives one frame starting at a negedge; optionally inverts the line for one cycle
  // at position spos of frame bit sbit (0 = start bit).
  task automatic send_frame(input logic [DW-1:0] d, input logic stop, input int sbit, input int spos);
    logic [DW+1:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < DW + 2; i++) begin
      for (int j = 0; j < CPB; j++) begin
        if (i == DW + 1 && j == 0) stop_cyc = ncyc;
        i_rx_serial = (i == sbit && j == spos) ? ~bits[i] : bits[i];
        @(negedge sysclk);
      end
    end
    i_rx_serial = 1'b1;
  endtask

  int bv, bf, bb;

  initial begin
    // 1: reset, idle line
    tick(5);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick(50);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_data", int'(o_data), 0);
    chk("rst_ferr", int'(o_frame_err), 0);
    chk("rst_ovr", int'(o_overrun), 0);

    // 2: clean frame 0x0B, consumer ready
    i_ready = 1'b1;
    bv = vcyc; bf = fcyc;
    send_frame(8'h0B, 1'b1, -1, 0);
    tick(20);
    chk("f0B_valid_cycles", vcyc - bv, 1);
    chk("f0B_data", int'(cap_data), 'h0B);
    chk("f0B_model", int'(m_last), 'h0B);
    chk("f0B_ferr", fcyc - bf, 0);
    chk("f0B_latency_ok", int'((vrise - stop_cyc) <= 2 + CPB / 2 + 2), 1);

    // 3: two-cycle glitch on idle line is a false start
    bv = vcyc; bf = fcyc; bb = bcyc;
    i_rx_serial = 1'b0;
    tick(2);
    i_rx_serial = 1'b1;
    tick(20);
    chk("glitch_busy_cycles", bcyc - bb, MID + 1);
    chk("glitch_valid", vcyc - bv, 0);
    chk("glitch_ferr", fcyc - bf, 0);

    // 4: bad stop bit, then recovery
    bv = vcyc; bf = fcyc;
    send_frame(8'hA5, 1'b0, -1, 0);
    tick(3);
    chk("a5_ferr_pulses", fcyc - bf, 1);
    chk("a5_valid", vcyc - bv, 0);
    tick(10);
    send_frame(8'h3C, 1'b1, -1, 0);
    tick(20);
    chk("f3C_data", int'(cap_data), 'h3C);
    chk("f3C_valid_cycles", vcyc - bv, 1);

    // 5: back-to-back with consumer stalled -> overrun
    i_ready = 1'b0;
    send_frame(8'h11, 1'b1, -1, 0);
    send_frame(8'h22, 1'b1, -1, 0);
    tick(20);
    chk("ovr_valid", int'(o_valid), 1);
    chk("ovr_data", int'(o_data), 'h11);
    chk("ovr_flag", int'(o_overrun), 1);
    chk("ovr_model_last", int'(m_last), 'h22);
    i_clr_err = 1'b1;
    tick(1);
    i_clr_err = 1'b0;
    chk("clr_ovr", int'(o_overrun), 0);
    chk("clr_keeps_valid", int'(o_valid), 1);
    i_ready = 1'b1;
    tick(1);
    i_ready = 1'b0;
    chk("accept_valid", int'(o_valid), 0);

    // 6: one-cycle spike mid bit 3 is voted out
    send_frame(8'hFF, 1'b1, 4, MID);
    tick(20);
    chk("spike_data", int'(o_data), 'hFF);
    chk("spike_valid", int'(o_valid), 1);

    // reset in the middle of the data bits
    i_rx_serial = 1'b0; tick(CPB);
    i_rx_serial = 1'b1; tick(CPB);
    i_rx_serial = 1'b0; tick(3);
    chk("midframe_busy", int'(o_busy), 1);
    @(posedge sysclk);
    #1 rst_n = 1'b0;
    i_rx_serial = 1'b1;
    @(negedge sysclk);
    chk("arst_valid", int'(o_valid), 0);
    chk("arst_busy", int'(o_busy), 0);
    chk("arst_data", int'(o_data), 0);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    i_ready = 1'b1;
    bv = vcyc;
    send_frame(8'h55, 1'b1, -1, 0);
    tick(20);
    chk("f55_data", int'(cap_data), 'h55);
    chk("f55_valid_cycles", vcyc - bv, 1);

    // break: line held low gives exactly one frame error
    bv = vcyc; bf = fcyc;
    i_rx_serial = 1'b0;
    tick(12 * CPB);
    chk("break_ferr", fcyc - bf, 1);
    chk("break_idle", int'(o_busy), 0);
    i_rx_serial = 1'b1;
    tick(20);
    chk("break_ferr_total", fcyc - bf, 1);
    chk("break_valid", vcyc - bv, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
